wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
- Multi-cycle wide adder. Adds two WORDS*N-bit operands on one shared N-bit ripple adder slice (nbit_full_adder: a, b, c_in -> sum, c_out), one N-bit word per clock, least-significant word first.
- The carry is registered between words.
- Sits between a requesting controller (start/busy/done handshake) and the adder slice, which it sequences. This gives wide arithmetic without a wide combinational carry chain.

Parameters:
N, 8, width of the adder slice in bits
WORDS, 4, number of N-bit words per operand; full operand width W = N*WORDS (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request to begin an addition; sampled only in IDLE
a_in  input  W  operand A; captured on the accepted start edge
b_in  input  W  operand B; captured on the accepted start edge
c_in  input  1  carry into word 0; captured on the accepted start edge
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse: result valid
sum_out  output  W  result of the last completed addition; held until the next completion
c_out  output  1  carry out of the top word of the last completed addition
ovf  output  1  signed (two's complement) overflow of the last completed W-bit addition

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum_out=0, c_out=0, ovf=0; working registers and word counter cleared. Reset mid-operation aborts the addition with no done pulse. The result registers stay 0 until a full addition completes.
- FSM has two states: IDLE and RUN.
- IDLE:
  - done is driven 0 except in the single cycle after completion (see RUN).
  - start=1 at an edge: load a_in, b_in into working shift registers A_w, B_w; load carry register cr=c_in; idx=0; go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - Adder slice inputs: a=A_w[N-1:0], b=B_w[N-1:0], c_in=cr.
  - Slice sum shifts into the top of accumulator S_w; A_w and B_w shift right by N.
  - cr <= slice c_out; idx <= idx+1.
- Completion: on the edge where idx == WORDS-1:
  - sum_out <= final S_w (including this word); c_out <= slice c_out.
  - ovf <= (a_top_sign == b_top_sign) && (sum_top_sign != a_top_sign), using the MSBs of the top word. Sign bits of the top word are captured at the start edge.
  - done <= 1; busy <= 0; state <= IDLE.
- Latency: start accepted at edge k; done=1 and sum_out/c_out/ovf valid during the cycle after edge k+WORDS. busy=1 for exactly WORDS cycles.
- done is high for exactly one cycle and returns to 0 at the next edge regardless of start.
- start while busy=1 is ignored: operands not re-captured, no effect on the running addition.
- start high in the done cycle (state already IDLE) is accepted: back-to-back additions run with a throughput of one per WORDS+1 cycles... no idle gap beyond the done cycle.
- sum_out/c_out/ovf change only on a completion edge or reset. They are stable while busy.
- Arithmetic is modulo 2^W. c_out is the unsigned carry out of bit W-1. With c_in=1 the result is a+b+1.
- Operand inputs may change freely after the start edge.

Test Plan (N=8, WORDS=4, W=32):
1. Assert rst for 2 cycles, then release -> busy=0, done=0, sum_out=0x00000000, c_out=0, ovf=0. Idle 5 cycles -> no change.
2. start with a=0x000000FF, b=0x00000001, c_in=0 -> busy high for 4 cycles, then done pulse for 1 cycle. Result: sum_out=0x00000100, c_out=0, ovf=0, carry crosses the word 0→1 boundary.
3. a=0xFFFFFFFF, b=0x00000000, c_in=1 -> sum_out=0x00000000, c_out=1, ovf=0 (carry ripples through all 4 words).
4. a=0x7FFFFFFF, b=0x00000001, c_in=0 -> sum_out=0x80000000, ovf=1, c_out=0. Then a=0x80000000, b=0x80000000 -> sum_out=0x00000000, c_out=1, ovf=1.
5. Handshake:
   - start=1 held continuously with new operands every cycle, first pair a=12, b=24, c_in=0 -> sum_out=36.
   - Operands presented while busy are ignored.
   - Pair a=10, b=13, c_in=1 presented in the done cycle -> accepted, sum_out=24 after the next 4 busy cycles.
6. Reset mid-operation: start a=25, b=22, then assert rst at the second RUN edge -> busy=0 immediately, no done pulse, sum_out=0. After release, start a=25, b=22 -> sum_out=47, c_out=0.

Source files
------------

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-cycle W = N*WORDS bit adder built on a single
// N-bit ripple slice. One word is added per clock, least-significant word
// first, with the inter-word carry held in a register.
//
// Handshake: start is sampled only in IDLE. An accepted start captures
// a_in/b_in/c_in on that edge. busy is high for exactly WORDS cycles. done is a
// one-cycle pulse that marks sum_out/c_out/ovf as fresh. A start presented
// in the done cycle is accepted, because the FSM is already back in IDLE.

// nbit_full_adder: N-bit ripple-carry adder slice.
module nbit_full_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  logic [N:0] w_c;

  assign w_c[0] = c_in;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign sum[gi]    = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = w_c[N];

endmodule

module wide_add_sequencer #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a_in,
  input  logic [N*WORDS-1:0]   b_in,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum_out,
  output logic                 c_out,
  output logic                 ovf
);

  localparam int W    = N * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_a_w;
  logic [W-1:0]    r_b_w;
  logic [W-1:0]    r_s_w;
  logic            r_cr;
  logic [IDXW-1:0] r_idx;
  logic            r_a_sign;
  logic            r_b_sign;
  logic            r_done;
  logic [W-1:0]    r_sum;
  logic            r_c_out;
  logic            r_ovf;

  logic [N-1:0]    w_slice_sum;
  logic            w_slice_cout;
  logic            w_accept;
  logic            w_last;

  // The shared slice always sees the low word of the working operands.
  nbit_full_adder #(.N(N)) u_slice (
    .a     (r_a_w[N-1:0]),
    .b     (r_b_w[N-1:0]),
    .c_in  (r_cr),
    .sum   (w_slice_sum),
    .c_out (w_slice_cout)
  );

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_idx == IDX_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> IDLE after the top word.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: busy follows the RUN state. The rest come from registers.
  always_comb begin
    busy    = (r_state == S_RUN);
    done    = r_done;
    sum_out = r_sum;
    c_out   = r_c_out;
    ovf     = r_ovf;
  end

  // Working datapath. Operands shift right one word per RUN cycle, and the
  // accumulator fills from the top so the result lands in place after WORDS
  // shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_w    <= '0;
      r_b_w    <= '0;
      r_s_w    <= '0;
      r_cr     <= 1'b0;
      r_idx    <= '0;
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
    end else if (w_accept) begin
      r_a_w    <= a_in;
      r_b_w    <= b_in;
      r_s_w    <= '0;
      r_cr     <= c_in;
      r_idx    <= '0;
      r_a_sign <= a_in[W-1];
      r_b_sign <= b_in[W-1];
    end else if (r_state == S_RUN) begin
      r_a_w <= r_a_w >> N;
      r_b_w <= r_b_w >> N;
      r_s_w <= {w_slice_sum, r_s_w[W-1:N]};
      r_cr  <= w_slice_cout;
      r_idx <= w_last ? '0 : r_idx + IDXW'(1);
    end
  end

  // Result registers and the done pulse. They update only on the completion edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_last) begin
        r_sum   <= {w_slice_sum, r_s_w[W-1:N]};
        r_c_out <= w_slice_cout;
        r_ovf   <= (r_a_sign == r_b_sign) && (w_slice_sum[N-1] != r_a_sign);
      end
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer (N=8, WORDS=4). Inputs are driven on
// the falling edge. Outputs are also sampled on the falling edge, before the
// next drive.
module tb_wide_add_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [31:0] sum_out;
  logic        c_out;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  wide_add_sequencer #(.N(8), .WORDS(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .c_in    (c_in),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .c_out   (c_out),
    .ovf     (ovf)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Checks WORDS busy cycles that follow an accepted start. The previous
  // result must stay unchanged during those cycles.
  task automatic expect_busy(input logic [31:0] prev_sum, input string tag);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
      check({tag, "_hold"}, sum_out, prev_sum);
      @(negedge clk);
    end
  endtask

  // Checks the done cycle and its results.
  task automatic expect_done(input logic [31:0] es, input logic ec, input logic eo,
                             input string tag);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy0"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, sum_out, es);
    check({tag, "_cout"}, 32'(c_out), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  // Runs one full addition and checks its timing and result.
  task automatic run_add(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input string tag);
    logic [31:0] prev;
    prev  = sum_out;
    start = 1'b1; a_in = a; b_in = b; c_in = ci;
    @(negedge clk);
    start = 1'b0; a_in = 32'hDEADBEEF; b_in = 32'h12345678; c_in = 1'b1;
    expect_busy(prev, tag);
    expect_done(es, ec, eo, tag);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    // Test 1: reset, then stay idle.
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", sum_out, 32'h0);
    check("rst_cout", 32'(c_out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_sum", sum_out, 32'h0);
    end

    // Tests 2-4: carry and overflow boundaries.
    run_add(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, "t2");
    run_add(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, "t3");
    run_add(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, "t4a");
    run_add(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, "t4b");

    // Test 5: start held high. Operands offered while busy are ignored, and a
    // pair offered in the done cycle is accepted.
    start = 1'b1; a_in = 32'd12; b_in = 32'd24; c_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("t5_busy", 32'(busy), 32'd1);
      check("t5_hold", sum_out, 32'h0);
      a_in = $urandom; b_in = $urandom; c_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    expect_done(32'd36, 1'b0, 1'b0, "t5a");
    a_in = 32'd10; b_in = 32'd13; c_in = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = 32'hFFFF0000; b_in = 32'h0000FFFF; c_in = 1'b0;
    expect_busy(32'd36, "t5b");
    expect_done(32'd24, 1'b0, 1'b0, "t5b");
    @(negedge clk);
    check("t5b_pulse", 32'(done), 32'd0);

    // Test 6: reset at the second RUN edge aborts the addition.
    start = 1'b1; a_in = 32'd25; b_in = 32'd22; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_sum", sum_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_nodone", 32'(done), 32'd0);
      check("t6_sum0", sum_out, 32'h0);
    end
    run_add(32'd25, 32'd22, 1'b0, 32'd47, 1'b0, 1'b0, "t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
